// File: rtl/regn_wr_arbiter.sv
// Round-robin write arbiter sharing one regn register among R requesters.
// One-cycle en/d write per grant, then a four-phase req/ack handshake.
module regn_wr_arbiter #(
   parameter  int N   = 8,
   parameter  int R   = 4,
   localparam int IDW = (R > 1) ? $clog2(R) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [R-1:0]   req,
   input  logic [R*N-1:0] wdata,
   output logic [R-1:0]   ack,
   output logic           reg_en,
   output logic [N-1:0]   reg_d,
   output logic [IDW-1:0] gnt_id,
   output logic           busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ACK  = 2'd2
   } state_t;

   state_t         state, state_nxt;
   logic [IDW-1:0] ptr, ptr_nxt;
   logic [IDW-1:0] win, id_nxt;
   logic [R-1:0]   ack_nxt;
   logic [N-1:0]   d_nxt;
   logic           en_nxt, busy_nxt;

   // Search ptr, ptr+1, ... wrapping; lowest offset with a request wins.
   function automatic logic [IDW-1:0] rr_pick(
      input logic [R-1:0]   r,
      input logic [IDW-1:0] p
   );
      logic [IDW-1:0] w;
      int             j;
      w = p;
      for (int k = R-1; k >= 0; k--) begin
         j = int'(p) + k;
         if (j >= R) j = j - R;
         if (r[j[IDW-1:0]]) w = j[IDW-1:0];
      end
      return w;
   endfunction

   always_comb begin
      win       = rr_pick(req, ptr);
      state_nxt = state;
      ptr_nxt   = ptr;
      ack_nxt   = ack;
      en_nxt    = 1'b0;
      d_nxt     = reg_d;
      id_nxt    = gnt_id;
      busy_nxt  = busy;
      unique case (state)
         IDLE: begin
            if (|req) begin
               id_nxt    = win;
               d_nxt     = wdata[int'(win)*N +: N];
               en_nxt    = 1'b1;
               busy_nxt  = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            ack_nxt         = '0;
            ack_nxt[gnt_id] = 1'b1;
            state_nxt       = ACK;
         end
         ACK: begin
            if (!req[gnt_id]) begin
               ack_nxt   = '0;
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
               if (gnt_id == IDW'(R-1)) ptr_nxt = '0;
               else                     ptr_nxt = gnt_id + 1'b1;
            end
         end
         default: begin
            ack_nxt   = '0;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         ack    <= '0;
         reg_en <= 1'b0;
         reg_d  <= '0;
         gnt_id <= '0;
         busy   <= 1'b0;
      end else begin
         state  <= state_nxt;
         ack    <= ack_nxt;
         reg_en <= en_nxt;
         reg_d  <= d_nxt;
         gnt_id <= id_nxt;
         busy   <= busy_nxt;
      end
   end

   // With a single requester the pointer is a constant.
   if (R > 1) begin : g_ptr
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) ptr <= '0;
         else      ptr <= ptr_nxt;
      end
   end else begin : g_ptr1
      assign ptr = '0;
   end

endmodule

// File: tb/tb_regn_wr_arbiter.sv
// Bench for regn_wr_arbiter: vector table, scoreboard and corner sequences.
// Includes a behavioural regn that captures on the falling edge.
module tb_regn_wr_arbiter;

   localparam int N = 8;
   localparam int R = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [R-1:0]   req = '0;
   logic [R*N-1:0] wdata = '0;
   logic [R-1:0]   ack;
   logic           reg_en;
   logic [N-1:0]   reg_d;
   logic [1:0]     gnt_id;
   logic           busy;
   logic [N-1:0]   q = '0;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [1:0]   id;
      logic [N-1:0] data;
   } exp_t;

   typedef struct {
      logic [R-1:0] req;
      logic [1:0]   id;
   } vec_t;

   exp_t         sb[$];
   exp_t         e_m;
   vec_t         tbl[9];
   logic [R-1:0] one = 1;

   regn_wr_arbiter #(.N(N), .R(R)) dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .wdata  (wdata),
      .ack    (ack),
      .reg_en (reg_en),
      .reg_d  (reg_d),
      .gnt_id (gnt_id),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   // The shared register
   always @(negedge clk) if (reg_en) q <= reg_d;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input int lim);
      int n;
      n = 0;
      while (ack == '0 && n < lim) begin
         step();
         n++;
      end
      if (ack == '0) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout: got ack=0 expected ack within %0d cycles", lim);
      end
   endtask

   task automatic wait_clear(input int lim);
      int n;
      n = 0;
      while ((ack != '0 || busy) && n < lim) begin
         step();
         n++;
      end
      if (ack != '0 || busy) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: got ack=%b busy=%b expected idle within %0d cycles",
                  ack, busy, lim);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #13;
      rst = 1'b1;
      step();
   endtask

   // Scoreboard: every write pulse must match the next expected grant
   always begin
      @(posedge clk);
      #1;
      if (reg_en) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got grant %0d expected none", gnt_id);
         end else begin
            e_m = sb.pop_front();
            chk("sb_id", 32'(gnt_id), 32'(e_m.id));
            chk("sb_data", 32'(reg_d), 32'(e_m.data));
         end
      end
   end

   always @(negedge clk) begin
      checks++;
      if (!$onehot0(ack) || (reg_en && dut.state != 2'd1) ||
          (busy != (dut.state != 2'd0))) begin
         errors++;
         $display("FAIL invariant: got ack=%b reg_en=%b busy=%b state=%0d expected onehot0 ack, en only in LOAD, busy==!IDLE",
                  ack, reg_en, busy, dut.state);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200us");
      $fatal(1);
   end

   initial begin
      logic [1:0] g;
      logic [1:0] id;

      tbl[0] = '{4'b0001, 2'd0};
      tbl[1] = '{4'b0001, 2'd0};
      tbl[2] = '{4'b1001, 2'd3};
      tbl[3] = '{4'b1010, 2'd1};
      tbl[4] = '{4'b0011, 2'd0};
      tbl[5] = '{4'b0110, 2'd1};
      tbl[6] = '{4'b1111, 2'd2};
      tbl[7] = '{4'b0100, 2'd2};
      tbl[8] = '{4'b1000, 2'd3};

      #3;
      chk("rst_ack", 32'(ack), 0);
      chk("rst_en", 32'(reg_en), 0);
      chk("rst_d", 32'(reg_d), 0);
      chk("rst_id", 32'(gnt_id), 0);
      chk("rst_busy", 32'(busy), 0);
      #9;
      rst = 1'b1;
      step();

      // Single write from requester 2
      wdata[2*N +: N] = 8'hA5;
      req = 4'b0100;
      sb.push_back('{2'd2, 8'hA5});
      step();
      chk("t1_en", 32'(reg_en), 1);
      chk("t1_d", 32'(reg_d), 32'hA5);
      chk("t1_id", 32'(gnt_id), 2);
      chk("t1_busy", 32'(busy), 1);
      step();
      chk("t1_en_off", 32'(reg_en), 0);
      chk("t1_ack", 32'(ack), 32'b0100);
      chk("t1_q", 32'(q), 32'hA5);
      step();
      chk("t1_ack_hold", 32'(ack), 32'b0100);
      req = '0;
      step();
      chk("t1_ack_off", 32'(ack), 0);
      chk("t1_busy_off", 32'(busy), 0);

      // All four requesting continuously from ptr=0
      do_reset();
      for (int i = 0; i < R; i++) wdata[i*N +: N] = 8'(8'hC0 + i);
      for (int n = 0; n < 5; n++) sb.push_back('{2'(n % 4), 8'(8'hC0 + n % 4)});
      req = '1;
      for (int n = 0; n < 5; n++) begin
         wait_ack(6);
         chk("rr_ack", 32'(ack), 32'(one << (n % 4)));
         chk("rr_q", 32'(q), 32'(8'hC0 + n % 4));
         g = 2'd0;
         for (int i = 0; i < R; i++) if (ack[i]) g = 2'(i);
         req[g] = 1'b0;
         wait_clear(6);
         req[g] = 1'b1;
      end
      req = '0;
      wait_clear(6);

      // Vector table, one grant per entry
      do_reset();
      for (int v = 0; v < 9; v++) begin
         for (int i = 0; i < R; i++) wdata[i*N +: N] = 8'(16*v + i + 1);
         id = tbl[v].id;
         req = tbl[v].req;
         sb.push_back('{id, wdata[int'(id)*N +: N]});
         wait_ack(6);
         chk("tbl_ack", 32'(ack), 32'(one << id));
         chk("tbl_q", 32'(q), 32'(wdata[int'(id)*N +: N]));
         req = '0;
         wait_clear(6);
         step();
      end

      // Winner withdraws req during LOAD
      wdata[1*N +: N] = 8'h5A;
      req = 4'b0010;
      sb.push_back('{2'd1, 8'h5A});
      step();
      chk("t3_en", 32'(reg_en), 1);
      req = '0;
      step();
      chk("t3_ack", 32'(ack), 32'b0010);
      chk("t3_q", 32'(q), 32'h5A);
      step();
      chk("t3_ack_off", 32'(ack), 0);
      chk("t3_busy", 32'(busy), 0);

      // wdata changes after the sample
      wdata[3*N +: N] = 8'h11;
      req = 4'b1000;
      sb.push_back('{2'd3, 8'h11});
      step();
      chk("t4_d", 32'(reg_d), 32'h11);
      wdata[3*N +: N] = 8'h22;
      step();
      chk("t4_d_hold", 32'(reg_d), 32'h11);
      chk("t4_ack", 32'(ack), 32'b1000);
      step();
      req = '0;
      step();
      chk("t4_busy", 32'(busy), 0);
      chk("t4_q", 32'(q), 32'h11);

      // Reset during LOAD, with ptr moved to 3 first
      wdata[2*N +: N] = 8'h33;
      req = 4'b0100;
      sb.push_back('{2'd2, 8'h33});
      wait_ack(6);
      req = '0;
      wait_clear(6);
      wdata[0*N +: N] = 8'h44;
      wdata[3*N +: N] = 8'h55;
      req = 4'b1001;
      sb.push_back('{2'd3, 8'h55});
      step();
      #2;
      rst = 1'b0;
      #1;
      chk("t5l_en", 32'(reg_en), 0);
      chk("t5l_d", 32'(reg_d), 0);
      chk("t5l_id", 32'(gnt_id), 0);
      chk("t5l_busy", 32'(busy), 0);
      chk("t5l_ack", 32'(ack), 0);
      #4;
      chk("t5l_q", 32'(q), 32'h33);
      rst = 1'b1;
      sb.push_back('{2'd0, 8'h44});
      wait_ack(6);
      chk("t5l_ack_new", 32'(ack), 32'b0001);
      chk("t5l_q_new", 32'(q), 32'h44);
      req = '0;
      wait_clear(6);

      // Reset during ACK; next grant must start from ptr=0
      wdata[1*N +: N] = 8'h66;
      req = 4'b0010;
      sb.push_back('{2'd1, 8'h66});
      step();
      step();
      chk("t5a_ack", 32'(ack), 32'b0010);
      #2;
      rst = 1'b0;
      #1;
      chk("t5a_ack_off", 32'(ack), 0);
      chk("t5a_busy", 32'(busy), 0);
      chk("t5a_d", 32'(reg_d), 0);
      req = '0;
      #3;
      rst = 1'b1;
      step();
      wdata[0*N +: N] = 8'h77;
      req = 4'b0011;
      sb.push_back('{2'd0, 8'h77});
      wait_ack(6);
      chk("t5a_ack_new", 32'(ack), 32'b0001);
      chk("t5a_q", 32'(q), 32'h77);
      req = '0;
      wait_clear(6);
      step();

      chk("sb_empty", 32'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
